// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer -- one Game-of-Life generation over a WIDTH x HEIGHT grid.
//
// Reads the current generation row by row from a row RAM (1-cycle read
// latency), keeps a TOP/MID/BOT window of three rows, evaluates one cell per
// clock through a single 8-input popcount and writes each finished row to the
// next-generation row RAM.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   start_i        begin a generation (only looked at in IDLE)
//   busy_o         high from the cycle after an accepted start through DONE
//   done_o         one-cycle completion pulse
//   rd_en_o        current-gen row read strobe
//   rd_addr_o      row being read
//   rd_data_i      row data, valid the cycle after rd_en_o
//   wr_en_o        next-gen row write strobe
//   wr_addr_o      row being written
//   wr_data_o      next-gen row, bit c = column c
//   population_o   live cells in the new generation, held until next start
//
// Build option: define LIFE_TORUS_EN for a toroidal grid (edges wrap, edge rows
// really read). Without it the grid has a dead border: out-of-range rows load
// as zero with no read issued, out-of-range columns read as zero.
//
// State | meaning
// IDLE  | waiting for start_i
// FETCH | issue a row read (suppressed for out-of-range rows on a dead border)
// LOAD  | capture rd_data_i into TOP, MID or BOT
// SWEEP | evaluate one column of the MID row per cycle
// WRITE | write the finished row, slide the window down
// DONE  | one-cycle completion pulse

module life_popcount8 (
  input  logic [7:0] bits_i,
  output logic [3:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 8; i++) cnt_o = cnt_o + {3'b000, bits_i[i]};
  end
endmodule

module life_gen_sequencer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int AW     = $clog2(HEIGHT),
  parameter int PW     = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [AW-1:0]    rd_addr_o,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic [PW-1:0]    population_o
);

`ifdef LIFE_TORUS_EN
  localparam logic TORUS = 1'b1;
`else
  localparam logic TORUS = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH-1);
  localparam logic [AW-1:0] ROW_LAST = AW'(HEIGHT-1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SWEEP, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [WIDTH-1:0] next_row_q, next_row_d;
  logic [PW-1:0]    pop_q, pop_d;

  // Row wanted by the current FETCH/LOAD pair. Slot 0 is row -1, slot 1 is
  // row 0; slot 2 is always the row below the current one, which during
  // priming (row_q = 0) is row 1 and afterwards is row_q+1 (row_q has
  // already advanced in WRITE).
  logic [AW-1:0] fetch_addr;
  logic          fetch_oob;

  always_comb begin
    fetch_addr = '0;
    fetch_oob  = 1'b0;
    case (slot_q)
      2'd0: begin
        fetch_addr = ROW_LAST;
        fetch_oob  = 1'b1;
      end
      2'd1: fetch_addr = '0;
      default: begin
        if (row_q == ROW_LAST) begin
          fetch_addr = '0;
          fetch_oob  = 1'b1;
        end else begin
          fetch_addr = row_q + AW'(1);
        end
      end
    endcase
  end

  logic [CW-1:0] col_l, col_r;
  logic          keep_l, keep_r;
  logic [7:0]    nbrs;
  logic [3:0]    nbr_cnt;
  logic          alive;

  assign col_l  = (col_q == '0)       ? COL_LAST : col_q - CW'(1);
  assign col_r  = (col_q == COL_LAST) ? '0       : col_q + CW'(1);
  assign keep_l = TORUS | (col_q != '0);
  assign keep_r = TORUS | (col_q != COL_LAST);

  assign nbrs = {top_q[col_l] & keep_l, top_q[col_q], top_q[col_r] & keep_r,
                 mid_q[col_l] & keep_l,               mid_q[col_r] & keep_r,
                 bot_q[col_l] & keep_l, bot_q[col_q], bot_q[col_r] & keep_r};

  life_popcount8 u_popcount (
    .bits_i (nbrs),
    .cnt_o  (nbr_cnt)
  );

  assign alive = (nbr_cnt == 4'd3) | (mid_q[col_q] & (nbr_cnt == 4'd2));

  logic [WIDTH-1:0] load_row;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    slot_d     = slot_q;
    top_d      = top_q;
    mid_d      = mid_q;
    bot_d      = bot_q;
    next_row_d = next_row_q;
    pop_d      = pop_q;
    load_row   = '0;
    rd_en_o    = 1'b0;
    rd_addr_o  = '0;
    wr_en_o    = 1'b0;
    done_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          row_d   = '0;
          slot_d  = '0;
          pop_d   = '0;
        end
      end
      S_FETCH: begin
        rd_en_o   = TORUS | ~fetch_oob;
        rd_addr_o = fetch_addr;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        load_row = (fetch_oob & ~TORUS) ? '0 : rd_data_i;
        case (slot_q)
          2'd0:    top_d = load_row;
          2'd1:    mid_d = load_row;
          default: bot_d = load_row;
        endcase
        if (slot_q != 2'd2) begin
          slot_d  = slot_q + 2'd1;
          state_d = S_FETCH;
        end else begin
          col_d   = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        next_row_d[col_q] = alive;
        pop_d = pop_q + PW'(alive);
        if (col_q == COL_LAST) state_d = S_WRITE;
        else                   col_d   = col_q + CW'(1);
      end
      S_WRITE: begin
        wr_en_o = 1'b1;
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          top_d   = mid_q;
          mid_d   = bot_q;
          row_d   = row_q + AW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      slot_q     <= '0;
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      next_row_q <= '0;
      pop_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      slot_q     <= slot_d;
      top_q      <= top_d;
      mid_q      <= mid_d;
      bot_q      <= bot_d;
      next_row_q <= next_row_d;
      pop_q      <= pop_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign wr_addr_o    = row_q;
  assign wr_data_o    = next_row_q;
  assign population_o = pop_q;

endmodule
